// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the count sequencer.
// Holds the controller state enumeration and the default counter width.
package count_seq_pkg;

    localparam int unsigned COUNT_WIDTH_DEFAULT = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/count_core.sv
// Loadable up/down counter with modulo-2^WIDTH arithmetic.
// Load takes priority over the count enable.
module count_core
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH = COUNT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            if (dir) begin
                count <= count + 1'b1;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// Start/stop/clear sequencer around a loadable up/down counter.
// Direction, mode and limit are captured at start and held until the next start.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int unsigned WIDTH = COUNT_WIDTH_DEFAULT
) (
    input  logic             clk_1Hz,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             dir,
    input  logic             one_shot,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             tc,
    output logic             done
);

    seq_state_t       state;
    seq_state_t       state_next;

    logic             lat_dir;
    logic             lat_one_shot;
    logic [WIDTH-1:0] lat_limit;
    logic             latch_en;

    logic             core_load;
    logic [WIDTH-1:0] core_load_val;
    logic             core_en;

    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] reload_val;
    logic             at_term;
    logic             start_cmd;

    assign term_val   = lat_dir ? lat_limit : '0;
    assign reload_val = lat_dir ? '0 : lat_limit;
    assign at_term    = (count == term_val);
    assign start_cmd  = start && !stop;

    always_ff @(posedge clk_1Hz or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_1Hz or negedge rst) begin
        if (!rst) begin
            lat_dir      <= 1'b0;
            lat_one_shot <= 1'b0;
            lat_limit    <= '0;
        end else if (latch_en) begin
            lat_dir      <= dir;
            lat_one_shot <= one_shot;
            lat_limit    <= limit;
        end
    end

    always_comb begin
        state_next    = state;
        latch_en      = 1'b0;
        core_load     = 1'b0;
        core_load_val = '0;
        core_en       = 1'b0;

        if (clear) begin
            state_next    = ST_IDLE;
            core_load     = 1'b1;
            core_load_val = '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_cmd) begin
                        latch_en      = 1'b1;
                        core_load     = 1'b1;
                        core_load_val = dir ? '0 : limit;
                        state_next    = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Terminal handling wins over a plain stop so a stop on the
                    // terminal edge still applies the wrap reload.
                    if (at_term) begin
                        if (!lat_one_shot) begin
                            core_load     = 1'b1;
                            core_load_val = reload_val;
                        end
                        if (stop) begin
                            state_next = ST_PAUSE;
                        end else if (lat_one_shot) begin
                            state_next = ST_DONE;
                        end
                    end else if (stop) begin
                        state_next = ST_PAUSE;
                    end else begin
                        core_en = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (start_cmd) begin
                        state_next = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk_1Hz),
        .rst_n    (rst),
        .load     (core_load),
        .load_val (core_load_val),
        .en       (core_en),
        .dir      (lat_dir),
        .count    (count)
    );

    assign running = (state == ST_RUN);
    assign done    = (state == ST_DONE);
    assign tc      = running && at_term;

endmodule

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 7, counter width in bits.
REQ-002 SHALL have port: clk_1Hz  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  level, sampled each edge; begin or resume counting.
REQ-005 SHALL have port: stop  input  1  level, sampled each edge; pause counting.
REQ-006 SHALL have port: clear  input  1  level, sampled each edge; abort to IDLE, count to 0.
REQ-007 SHALL have port: dir  input  1  1 = count up, 0 = count down.
REQ-008 SHALL have port: one_shot  input  1  1 = stop at terminal, 0 = wrap.
REQ-009 SHALL have port: limit  input  WIDTH  terminal value for up-count and start value for down-count.
REQ-010 SHALL have port: count  output  WIDTH  current count, registered.
REQ-011 SHALL have port: running  output  1  high while in RUN.
REQ-012 SHALL have port: tc  output  1  terminal-count indication.
REQ-013 SHALL have port: done  output  1  high while in DONE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-015 Command priority SHALL be: clear, then stop, then start.
- start is ignored whenever stop is also high.
REQ-016 clear high at any edge SHALL force IDLE with count = 0, in any state.
REQ-017 start in IDLE or DONE SHALL latch dir, one_shot and limit into internal registers and enter RUN.
- count loads 0 (dir = 1) or limit (dir = 0).
REQ-018 Load/step timing:
- Start sampled at edge N: count shows the start value after edge N.
- First step occurs at edge N+1.
REQ-019 In RUN, count SHALL step by 1 per edge in the latched direction.
- Terminal value: latched limit (up) or 0 (down).
REQ-020 tc SHALL be high exactly when state = RUN and count = terminal value.
- tc is a decode of registered state; it is 1 cycle wide per pass.
REQ-021 At an edge in RUN with count = terminal, one_shot latched = 0: count SHALL reload the start value and stay in RUN.
REQ-022 At an edge in RUN with count = terminal, one_shot latched = 1: SHALL enter DONE with count held at terminal.
REQ-023 stop in RUN SHALL enter PAUSE with count held.
- start in PAUSE resumes RUN with no reload.
- stop in PAUSE, IDLE or DONE is a no-op.
REQ-024 stop at the same edge as a terminal event SHALL enter PAUSE.
- count takes its terminal-step value: reload value for wrap, held terminal for one-shot.
REQ-025 Changes on dir, one_shot or limit during RUN or PAUSE SHALL have no effect until the next start from IDLE or DONE.
REQ-026 Latched limit = 0 with dir = 1 SHALL make the start value the terminal value.
- wrap mode: tc is high every RUN cycle.
- one-shot mode: DONE is entered one edge after start.
REQ-027 Count arithmetic SHALL be modulo 2^WIDTH.
- Overflow is unreachable because terminal detection precedes the step.
REQ-028 running and done SHALL be pure decodes of the state register, with no combinational path from inputs.

Reset
REQ-029 rst low SHALL immediately (asynchronously) set: state IDLE, count 0, latched dir/one_shot/limit 0, running 0, tc 0, done 0.
REQ-030 Reset deassertion SHALL be synchronous to clk_1Hz externally; the first edge after release evaluates commands normally.
REQ-031 Reset asserted mid-RUN or mid-PAUSE SHALL discard the count without any tc or done pulse.

Structure
REQ-032 Package count_seq_pkg SHALL hold the state enumeration and the default WIDTH constant.
REQ-033 A sub-module count_core SHALL implement the loadable up/down counter:
- inputs: load, load_val, en, dir
- output: count
- count_seq_ctrl contains the FSM and the latching registers.
REQ-034 count_seq_ctrl SHALL be 120-400 RTL lines total including count_core.

Verification
REQ-035 Up/wrap: limit=5, dir=1, one_shot=0, pulse start -> count 0,1,2,3,4,5,0,1...; tc high only at each 5.
REQ-036 Down/one-shot: limit=3, dir=0, one_shot=1, start -> count 3,2,1,0; tc at 0; then done=1, running=0, count holds 0.
REQ-037 Pause/resume: run up to 4, stop 3 cycles, then start -> count holds 4 while running=0, then resumes at 5 (no reload).
REQ-038 Priority: clear+start+stop asserted together in RUN -> IDLE, count=0; later start+stop together in IDLE -> remains IDLE.
REQ-039 Latching and async reset:
- Change limit 5->2 mid-RUN -> wrap still at 5.
- Drop rst between edges at count=3 -> count=0 and state IDLE immediately, no tc or done.
REQ-040 Edge case: limit=0, dir=1, one_shot=1, start -> count 0, tc high one cycle, done=1 on the next edge.
